// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : button_event_queue
// Purpose  : Turns the eight debounced button levels into press/release event
//            records. Records wait in a small FIFO that software reads over a
//            ren/wen/address register interface. irq is high while events are
//            queued.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            btn_level[7:0] - debounced levels (DownR,UpR,LeftR,RightR,
//                             DownL,UpL,LeftL,RightL)
//            ren, wen       - one-cycle read / write strobes
//            address[31:0]  - byte address, only [3:2] decoded
//            data_in[31:0]  - write data
//            data_out[31:0] - registered read data (valid the cycle after ren)
//            irq            - FIFO non-empty
// Registers: 0 STATUS (R)   [24]=empty [20:16]=count [8]=overflow [7:0]=pending
//            1 EVENT  (R)   head record, popped by the read
//            2 MASK   (R/W) [7:0] per-button enable
//            3 CTRL   (W)   bit0 flush FIFO+pending, bit1 clear overflow
// Option   : BTN_TIMESTAMP_EN - adds a free-running 16-bit cycle counter whose
//            value at edge detection is placed in event bits [31:16].
// Revision : 1.0 - initial release
// ============================================================================
module button_event_queue #(
    parameter int   DEPTH       = 8,
    parameter int   NBTN        = 8,
    parameter logic PRESS_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  btn_level,
    input  logic        ren,
    input  logic        wen,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        irq
);

    localparam int         c_AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] c_DEPTH_CNT   = 5'(DEPTH);
    localparam logic [1:0] c_REG_STATUS  = 2'd0;
    localparam logic [1:0] c_REG_EVENT   = 2'd1;
    localparam logic [1:0] c_REG_MASK    = 2'd2;
    localparam logic [1:0] c_REG_CTRL    = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NBTN-1:0] r_prev;
    logic [NBTN-1:0] r_pending;
    logic [NBTN-1:0] r_kind;       // 1 = pending edge was a press
    logic [NBTN-1:0] r_mask;
    logic            r_overflow;
    logic [31:0]     r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [4:0]      r_count;
    logic [31:0]     r_data_out;
    logic            r_irq;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [1:0]      w_reg;
    logic            w_pop;
    logic            w_flush;
    logic            w_clr_ovf;
    logic            w_wr_mask;
    logic [NBTN-1:0] w_edge;
    logic [NBTN-1:0] w_press_now;
    logic            w_svc;
    logic [2:0]      w_svc_id;
    logic            w_full;
    logic            w_push;
    logic            w_drop;
    logic [15:0]     w_evt_ts;
    logic [31:0]     w_push_word;
    logic [NBTN-1:0] w_pending_nxt;
    logic            w_overflow_nxt;
    logic [4:0]      w_count_nxt;
    logic [31:0]     w_rd_data;
    logic            w_unused_bits;

    assign w_reg     = address[3:2];
    assign w_pop     = ren && (w_reg == c_REG_EVENT) && (r_count != 5'd0);
    assign w_flush   = wen && (w_reg == c_REG_CTRL) && data_in[0];
    assign w_clr_ovf = wen && (w_reg == c_REG_CTRL) && data_in[1];
    assign w_wr_mask = wen && (w_reg == c_REG_MASK);

    // Masked buttons never produce edges, so they cannot touch pending/kind.
    assign w_edge      = (btn_level ^ r_prev) & r_mask;
    assign w_press_now = ~(btn_level ^ {NBTN{PRESS_LEVEL}});

    // Lowest-index pending button wins the single push slot this cycle.
    always_comb begin
        w_svc    = 1'b0;
        w_svc_id = 3'd0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_svc    = 1'b1;
                w_svc_id = 3'(i);
            end
        end
    end

    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    // Flush cancels the service outright: the record is neither stored nor
    // counted as lost.
    assign w_full = (r_count == c_DEPTH_CNT);
    assign w_push = w_svc && !w_flush && (!w_full || w_pop);
    assign w_drop = w_svc && !w_flush && w_full && !w_pop;

    assign w_push_word = {w_evt_ts, 7'd0, 1'b1, 3'd0, r_kind[w_svc_id], 1'b0, w_svc_id};

    // A new edge on the button being serviced re-arms its pending bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_svc) begin
            w_pending_nxt[w_svc_id] = 1'b0;
        end
        w_pending_nxt = w_pending_nxt | w_edge;
        if (w_wr_mask) begin
            w_pending_nxt = w_pending_nxt & data_in[NBTN-1:0];
        end
        if (w_flush) begin
            w_pending_nxt = '0;
        end
    end

    // Setting takes priority over a same-cycle clear so a loss is never hidden.
    assign w_overflow_nxt = (r_overflow & ~w_clr_ovf) | w_drop | (|(w_edge & r_pending));

    assign w_count_nxt = w_flush ? 5'd0
                                 : (r_count + {4'd0, w_push} - {4'd0, w_pop});

    always_comb begin
        w_rd_data = 32'd0;
        case (w_reg)
            c_REG_STATUS: w_rd_data = {7'd0, (r_count == 5'd0), 3'd0, r_count,
                                       7'd0, r_overflow, r_pending};
            c_REG_EVENT:  w_rd_data = (r_count != 5'd0) ? r_mem[r_rd_ptr] : 32'd0;
            c_REG_MASK:   w_rd_data = {24'd0, r_mask};
            default:      w_rd_data = 32'd0;
        endcase
    end

    assign w_unused_bits = ^{address[31:4], address[1:0], data_in[31:NBTN]};

    // ------------------------------------------------------------------
    // Optional timestamp capture
    // ------------------------------------------------------------------
`ifdef BTN_TIMESTAMP_EN
    logic [15:0] r_ts;
    logic [15:0] r_ts_btn [NBTN];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts <= 16'd0;
            for (int i = 0; i < NBTN; i++) begin
                r_ts_btn[i] <= 16'd0;
            end
        end else begin
            r_ts <= r_ts + 16'd1;
            for (int i = 0; i < NBTN; i++) begin
                if (w_edge[i]) begin
                    r_ts_btn[i] <= r_ts;
                end
            end
        end
    end

    assign w_evt_ts = r_ts_btn[w_svc_id];
`else
    assign w_evt_ts = 16'd0;
`endif

    // ------------------------------------------------------------------
    // FIFO storage (contents are don't-care while count is zero)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_word;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev     <= btn_level;
            r_pending  <= '0;
            r_kind     <= '0;
            r_mask     <= '1;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= 5'd0;
            r_data_out <= 32'd0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= btn_level;
            r_pending  <= w_pending_nxt;
            r_kind     <= (r_kind & ~w_edge) | (w_edge & w_press_now);
            r_overflow <= w_overflow_nxt;
            r_count    <= w_count_nxt;
            r_irq      <= (w_count_nxt != 5'd0);
            if (w_wr_mask) begin
                r_mask <= data_in[NBTN-1:0];
            end
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
            end
            if (ren) begin
                r_data_out <= w_rd_data;
            end
        end
    end

    assign data_out = r_data_out;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_button_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_queue
// Purpose  : Self-checking bench for button_event_queue. A driver applies one
//            input vector per cycle on the falling edge and advances a
//            queue-based reference model; the model's expected data_out/irq
//            go into a scoreboard that a separate monitor drains after each
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_queue;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  btn_level;
    logic        ren;
    logic        wen;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        irq;

    always #5 clk = ~clk;

    button_event_queue #(
        .DEPTH       (DEPTH),
        .NBTN        (8),
        .PRESS_LEVEL (1'b0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_level (btn_level),
        .ren       (ren),
        .wen       (wen),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .irq       (irq)
    );

    typedef struct {
        logic [31:0] dout;
        logic        irq;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: events as a queue of words, per-button pending flags.
    logic [31:0] m_q[$];
    logic [7:0]  m_prev, m_pend, m_kind, m_mask;
    logic        m_ovf;
    logic [31:0] m_dout;
    logic [15:0] m_ts;
    logic [15:0] m_tsb [8];
    logic [7:0]  btn;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_step();
        logic [31:0] rv;
        logic [31:0] word;
        logic [7:0]  npend;
        logic        novf;
        logic [1:0]  a;
        logic        pop, flush;
        int          sel;
        if (rst) begin
            m_q.delete();
            m_pend = 8'h00;
            m_kind = 8'h00;
            m_ovf  = 1'b0;
            m_mask = 8'hFF;
            m_dout = 32'd0;
            m_prev = btn_level;
            m_ts   = 16'd0;
            for (int i = 0; i < 8; i++) m_tsb[i] = 16'd0;
        end else begin
            a = address[3:2];
            case (a)
                2'd0:    rv = {7'd0, (m_q.size() == 0), 3'd0, 5'(m_q.size()), 7'd0, m_ovf, m_pend};
                2'd1:    rv = (m_q.size() > 0) ? m_q[0] : 32'd0;
                2'd2:    rv = {24'd0, m_mask};
                default: rv = 32'd0;
            endcase
            pop   = ren && (a == 2'd1) && (m_q.size() > 0);
            flush = wen && (a == 2'd3) && data_in[0];
            novf  = m_ovf && !(wen && (a == 2'd3) && data_in[1]);
            npend = m_pend;
            sel = -1;
            for (int i = 7; i >= 0; i--) if (m_pend[i]) sel = i;
            if (pop) void'(m_q.pop_front());
            if (sel >= 0 && !flush) begin
`ifdef BTN_TIMESTAMP_EN
                word = {m_tsb[sel], 7'd0, 1'b1, 3'd0, m_kind[sel], 1'b0, 3'(sel)};
`else
                word = {16'd0, 7'd0, 1'b1, 3'd0, m_kind[sel], 1'b0, 3'(sel)};
`endif
                if (m_q.size() < DEPTH) m_q.push_back(word);
                else novf = 1'b1;
                npend[sel] = 1'b0;
            end
            for (int i = 0; i < 8; i++) begin
                if (btn_level[i] != m_prev[i] && m_mask[i]) begin
                    if (m_pend[i]) novf = 1'b1;
                    npend[i]  = 1'b1;
                    m_kind[i] = (btn_level[i] == 1'b0);
                    m_tsb[i]  = m_ts;
                end
            end
            if (wen && a == 2'd2) begin
                m_mask = data_in[7:0];
                npend  = npend & data_in[7:0];
            end
            if (flush) begin
                m_q.delete();
                npend = 8'h00;
            end
            m_pend = npend;
            m_ovf  = novf;
            m_prev = btn_level;
            m_ts   = m_ts + 16'd1;
            if (ren) m_dout = rv;
        end
        sb.push_back('{m_dout, (m_q.size() != 0)});
    endtask

    // One cycle of stimulus; upper/lower address bits are randomised because
    // only [3:2] should matter.
    task automatic cyc(input logic r, input logic [7:0] b, input logic re,
                       input logic we, input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        rst       = r;
        btn_level = b;
        ren       = re;
        wen       = we;
        address   = {28'($urandom()), a, 2'($urandom())};
        data_in   = d;
        btn       = b;
        model_step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, btn, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic rd(input logic [1:0] a);
        cyc(1'b0, btn, 1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b0, btn, 1'b0, 1'b1, a, d);
    endtask

    task automatic set_btn(input logic [7:0] b);
        cyc(1'b0, b, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("data_out", data_out, e.dout);
                check("irq", {31'd0, irq}, {31'd0, e.irq});
            end
        end
    end

    initial begin : driver
        logic [7:0]  b;
        logic        r, re, we;
        logic [1:0]  a;
        logic [31:0] d;
        rst = 1'b1; btn_level = 8'hFF; ren = 1'b0; wen = 1'b0;
        address = 32'd0; data_in = 32'd0; btn = 8'hFF;

        // Reset with all buttons released, then quiet period.
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(10);
        rd(2'd0);
        rd(2'd1);

        // Press and release button 2.
        set_btn(8'hFB);
        idle(10);
        set_btn(8'hFF);
        idle(3);
        rd(2'd1);
        rd(2'd1);
        idle(2);

        // Buttons 0 and 7 together.
        set_btn(8'h7E);
        idle(2);
        rd(2'd0);
        rd(2'd1);
        rd(2'd1);
        set_btn(8'hFF);
        idle(3);
        rd(2'd1);
        rd(2'd1);

        // Nine events with no reads: one must be lost.
        for (int i = 0; i < 8; i++) begin
            b = btn;
            b[i] = 1'b0;
            set_btn(b);
            idle(1);
        end
        set_btn(btn | 8'h01);
        idle(3);
        rd(2'd0);
        wr(2'd3, 32'd2);
        rd(2'd0);
        rd(2'd1);
        set_btn(8'hFF);
        idle(10);
        wr(2'd3, 32'd3);
        rd(2'd0);

        // Masking and flush.
        wr(2'd2, 32'hFE);
        rd(2'd2);
        set_btn(8'hFE);
        idle(2);
        set_btn(8'hFF);
        idle(2);
        rd(2'd1);
        rd(2'd0);
        wr(2'd2, 32'hFF);
        set_btn(8'hF1);
        idle(4);
        rd(2'd0);
        wr(2'd3, 32'd1);
        rd(2'd0);
        rd(2'd3);
        set_btn(8'hFF);
        idle(4);
        wr(2'd3, 32'd1);

`ifdef BTN_TIMESTAMP_EN
        // Timestamp capture and counter wrap.
        cyc(1'b1, 8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(100);
        set_btn(8'hFD);
        idle(2);
        rd(2'd1);
        idle(65536);
        set_btn(8'hFF);
        idle(2);
        rd(2'd1);
`endif

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            b = btn;
            if ($urandom_range(3) == 0) b[$urandom_range(7)] = ~b[$urandom_range(7)];
            re = ($urandom_range(2) == 0);
            we = ($urandom_range(15) == 0);
            a  = 2'($urandom_range(3));
            d  = $urandom();
            if (we && a == 2'd3) d[0] = ($urandom_range(3) == 0);
            if (we && a == 2'd2 && $urandom_range(1) == 1) d[7:0] = 8'hFF;
            r  = ($urandom_range(499) == 0);
            cyc(r, b, re, we, a, d);
        end
        idle(3);

        @(posedge clk);
        #2;
        check("scoreboard_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
